// File: rtl/pwm_driver_pkg.sv
// PWM driver shared definitions.
// Register map, CTRL bit positions and core FSM states.
package pwm_driver_pkg;

  localparam logic [3:0] REG_CTRL     = 4'h0;
  localparam logic [3:0] REG_PRESCALE = 4'h4;
  localparam logic [3:0] REG_PERIOD   = 4'h8;
  localparam logic [3:0] REG_DUTY     = 4'hC;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_POL = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } pwm_state_t;

endpackage

// File: rtl/pwm_cfg_if.sv
// Register-slave to PWM core configuration bundle.
// The slave drives (master); the timing core consumes (slave).
interface pwm_cfg_if #(
  parameter int CNT_WIDTH      = 32,
  parameter int PRESCALE_WIDTH = 16
);

  logic [1:0]                cfg_ctrl;
  logic [PRESCALE_WIDTH-1:0] cfg_prescale;
  logic [CNT_WIDTH-1:0]      cfg_period;
  logic [CNT_WIDTH-1:0]      cfg_duty;
  logic                      cfg_update;

  modport master (
    output cfg_ctrl,
    output cfg_prescale,
    output cfg_period,
    output cfg_duty,
    output cfg_update
  );

  modport slave (
    input cfg_ctrl,
    input cfg_prescale,
    input cfg_period,
    input cfg_duty,
    input cfg_update
  );

endinterface

// File: rtl/pwm_core_prescaler.sv
// PWM tick prescaler: pcnt runs 0..prescale,
// tick marks the last clock of each prescale window.
module pwm_prescaler #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [W-1:0] prescale,
  output logic         tick
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] pcnt;

  assign tick = (pcnt == prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (clear || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + ONE;
    end
  end

endmodule

// File: rtl/pwm_core.sv
// PWM timing core: FSM, shadow registers,
// period counter and registered output.
module pwm_core
  import pwm_driver_pkg::*;
#(
  parameter int CNT_WIDTH      = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic     ACLK,
  input  logic     ARESETN,
  pwm_cfg_if.slave cfg,
  output logic     pwm_out,
  output logic     period_done,
  output logic     running,
  output logic     update_pending
);

  localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

  pwm_state_t state, state_nxt;

  logic [CNT_WIDTH-1:0]      cnt;
  logic [CNT_WIDTH-1:0]      sh_period;
  logic [CNT_WIDTH-1:0]      sh_duty;
  logic [PRESCALE_WIDTH-1:0] sh_prescale;
  logic                      sh_pol;
  logic                      pending;

  logic en;
  logic idle;
  logic tick;
  logic boundary;
  logic load;
  logic active;

  assign en       = cfg.cfg_ctrl[CTRL_EN];
  assign idle     = (state == IDLE);
  assign boundary = !idle && tick &&
                    (cnt == sh_period - C_ONE);
  assign load     = boundary &&
                    (pending || cfg.cfg_update);
  assign active   = (cnt < sh_duty);

  assign period_done    = boundary;
  assign running        = !idle;
  assign update_pending = pending;

  pwm_prescaler #(
    .W (PRESCALE_WIDTH)
  ) u_presc (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .clear    (idle),
    .prescale (sh_prescale),
    .tick     (tick)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A period only ends at a boundary; EN is live.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (en && (cfg.cfg_period != '0)) begin
          state_nxt = RUN;
        end
      end
      RUN, STOP: begin
        if (boundary) begin
          if (!en ||
              (load && (cfg.cfg_period == '0))) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = RUN;
          end
        end else begin
          state_nxt = en ? RUN : STOP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sh_period   <= '0;
      sh_duty     <= '0;
      sh_prescale <= '0;
      sh_pol      <= 1'b0;
    end else if (idle || load) begin
      sh_period   <= cfg.cfg_period;
      sh_duty     <= cfg.cfg_duty;
      sh_prescale <= cfg.cfg_prescale;
      sh_pol      <= cfg.cfg_ctrl[CTRL_POL];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pending <= 1'b0;
    end else if (idle || load) begin
      pending <= 1'b0;
    end else if (cfg.cfg_update) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt <= '0;
    end else if (idle) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= boundary ? '0 : cnt + C_ONE;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pwm_out <= 1'b0;
    end else if (idle) begin
      pwm_out <= sh_pol;
    end else begin
      pwm_out <= active ^ sh_pol;
    end
  end

endmodule

// File: tb/tb_pwm_core.sv
// Directed self-checking bench for pwm_core.
// Samples 1 time unit after each rising edge.
module tb_pwm_core;

  logic clk;
  logic rst_n;
  logic pwm_out;
  logic period_done;
  logic running;
  logic update_pending;

  int total;
  int bad;

  logic [63:0] pw_v;
  logic [63:0] pd_v;
  logic [63:0] rn_v;
  logic [63:0] up_v;

  pwm_cfg_if #(
    .CNT_WIDTH      (32),
    .PRESCALE_WIDTH (16)
  ) cfg ();

  pwm_core #(
    .CNT_WIDTH      (32),
    .PRESCALE_WIDTH (16)
  ) dut (
    .ACLK           (clk),
    .ARESETN        (rst_n),
    .cfg            (cfg),
    .pwm_out        (pwm_out),
    .period_done    (period_done),
    .running        (running),
    .update_pending (update_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  // bit i set where (i % per) lies in [st, st+len)
  function automatic logic [63:0] pat(input int n,
                                      input int per,
                                      input int st,
                                      input int len);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      if ((i % per) >= st && (i % per) < st + len)
        r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic capture(input int n);
    pw_v = '0;
    pd_v = '0;
    rn_v = '0;
    up_v = '0;
    for (int i = 0; i < n; i++) begin
      step(1);
      pw_v[i] = pwm_out;
      pd_v[i] = period_done;
      rn_v[i] = running;
      up_v[i] = update_pending;
    end
  endtask

  task automatic do_reset();
    cfg.cfg_ctrl   = 2'b00;
    cfg.cfg_update = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic setup(input int presc,
                       input int per,
                       input int duty);
    cfg.cfg_prescale = 16'(presc);
    cfg.cfg_period   = 32'(per);
    cfg.cfg_duty     = 32'(duty);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    cfg.cfg_ctrl   = 2'b00;
    cfg.cfg_update = 1'b0;
    setup(0, 10, 3);

    // reset state
    step(2);
    chk("rst_pwm", 64'(pwm_out), 64'd0);
    chk("rst_pd", 64'(period_done), 64'd0);
    chk("rst_run", 64'(running), 64'd0);
    chk("rst_pend", 64'(update_pending), 64'd0);
    rst_n = 1'b1;
    step(1);

    // presc 0, period 10, duty 3
    cfg.cfg_ctrl = 2'b01;
    step(1);
    capture(20);
    chk("p10d3_pwm", pw_v, pat(20, 10, 0, 3));
    chk("p10d3_pd", pd_v, pat(20, 10, 8, 1));
    chk("p10d3_run", 64'(running), 64'd1);

    // presc 4, period 4, duty 2
    do_reset();
    setup(4, 4, 2);
    cfg.cfg_ctrl = 2'b01;
    step(1);
    capture(40);
    chk("ps4_pwm", pw_v, pat(40, 20, 0, 10));
    chk("ps4_pd", pd_v, pat(40, 20, 18, 1));

    // duty 0
    do_reset();
    setup(0, 10, 0);
    cfg.cfg_ctrl = 2'b01;
    step(1);
    capture(20);
    chk("d0_pwm", pw_v, 64'd0);

    // duty above period
    do_reset();
    setup(0, 10, 12);
    cfg.cfg_ctrl = 2'b01;
    step(1);
    capture(20);
    chk("d12_pwm", pw_v, pat(20, 10, 0, 10));
    chk("d12_pd", pd_v, pat(20, 10, 8, 1));

    // mid-period duty write 3 -> 7
    do_reset();
    setup(0, 10, 3);
    cfg.cfg_ctrl = 2'b01;
    step(1);
    step(1);
    cfg.cfg_duty   = 32'd7;
    cfg.cfg_update = 1'b1;
    step(1);
    cfg.cfg_update = 1'b0;
    chk("upd_pend_set", 64'(update_pending), 64'd1);
    capture(18);
    chk("upd_pwm", pw_v,
        pat(18, 100, 0, 1) | pat(18, 100, 8, 7));
    chk("upd_pend_v", up_v, pat(18, 100, 0, 7));
    chk("upd_pend_clr", 64'(update_pending), 64'd0);

    // active-low polarity
    do_reset();
    setup(0, 8, 2);
    cfg.cfg_ctrl = 2'b10;
    step(2);
    chk("pol_idle_pre", 64'(pwm_out), 64'd1);
    cfg.cfg_ctrl = 2'b11;
    step(1);
    capture(16);
    chk("pol_pwm", pw_v, pat(16, 8, 2, 6));
    cfg.cfg_ctrl = 2'b10;
    for (int k = 0; k < 30 && running; k++) step(1);
    chk("pol_stop_run", 64'(running), 64'd0);
    step(1);
    chk("pol_idle_pwm", 64'(pwm_out), 64'd1);

    // EN dropped at cnt 4
    do_reset();
    setup(0, 10, 3);
    cfg.cfg_ctrl = 2'b01;
    step(1);
    step(4);
    cfg.cfg_ctrl = 2'b00;
    capture(8);
    chk("stop_run_v", rn_v, pat(8, 100, 0, 5));
    chk("stop_pd_v", pd_v, pat(8, 100, 4, 1));

    // async reset mid-run
    do_reset();
    cfg.cfg_ctrl = 2'b01;
    step(1);
    step(1);
    chk("arst_pre_pwm", 64'(pwm_out), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pwm", 64'(pwm_out), 64'd0);
    chk("arst_run", 64'(running), 64'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_restart", 64'(running), 64'd1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
